hps_sensor_cfg_bank: RTL and testbench
======================================

// Module: hps_sensor_cfg_bank
// PURPOSE
//  Multi-channel HPS-to-FPGA control block on the h2f Avalon-MM bridge.
//  - Provides NUM_BUF frame-buffer address registers and a one-cycle start strobe.
//  - Queues sensor register writes (reg address + data) per channel in an internal FIFO.
//  - Drains each FIFO into its SCCB/I2C master with a valid/busy handshake.
//  - Adds readback, per-channel overflow/status flags and a bounded handshake timeout.
// PARAMETERS
//  NUM_CH      2     sensor channels, 1..8
//  NUM_BUF     4     32-bit buffer address registers, 1..16
//  REG_AW      16    sensor register address width
//  REG_DW      8     sensor register data width; REG_AW+REG_DW <= 32
//  FIFO_DEPTH  16    entries per channel FIFO, power of 2, >= 2
//  ACK_TMO     1023  cycles to wait for busy assertion before abandoning a command
// PORTS
//  clk_sys        in   1                system clock; all logic in this domain
//  reset_n        in   1                asynchronous, active-low reset
//  avl_address    in   16               Avalon word address
//  avl_chipselect in   1                Avalon chipselect
//  avl_write      in   1                write strobe; qualified by chipselect
//  avl_writedata  in   32               write data
//  avl_read       in   1                read strobe; qualified by chipselect
//  avl_readdata   out  32               read data; fixed read latency 1
//  buf_addr       out  NUM_BUF*32       buffer address registers, reg i at [32i+31:32i]
//  start_wr       out  1                one-cycle image-to-DDR start strobe
//  cmd_valid      out  NUM_CH           one-cycle command issue strobe per channel
//  cmd_addr       out  NUM_CH*REG_AW    sensor register address; held until next issue
//  cmd_data       out  NUM_CH*REG_DW    sensor register data; held until next issue
//  cmd_ready      in   NUM_CH           sensor master idle (1) / busy (0)
// BEHAVIOUR
//  Address map (wr = chipselect & write, rd = chipselect & read):
//   0..NUM_BUF-1  RW  buf_addr[i]; full 32-bit write; takes effect next cycle.
//   0x8000+ch     W   push {wdata[REG_AW+REG_DW-1:REG_AW], wdata[REG_AW-1:0]} into FIFO ch;
//                     ch >= NUM_CH is ignored.
//   0xFFFE        R   STATUS: [7:0] FIFO empty per ch, [15:8] sticky overflow per ch,
//                     [23:16] sticky timeout per ch; unused bits read 0.
//                 W   write 1 to clear: wdata[15:8] clears overflow, [23:16] clears timeout.
//   0xFFFF        W   start_wr=1 for exactly the next cycle if wdata[0]=1; otherwise 0.
//   Unmapped reads return 0; unmapped writes are ignored.
//  Readback: avl_readdata is registered, valid the cycle after rd; holds its value otherwise.
//  FIFO, per channel:
//   - Push on full: entry dropped, overflow[ch] set. Full is judged before a same-cycle pop.
//   - Push and pop in the same cycle on a non-full FIFO: both complete, count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Drain FSM, per channel:
//   IDLE: if !empty & cmd_ready -> pop; load cmd_addr/cmd_data; go to ISSUE.
//   ISSUE: cmd_valid=1 for one cycle; clear tmo counter; go to WAIT_BUSY.
//   WAIT_BUSY: on !cmd_ready -> WAIT_DONE; at counter == ACK_TMO -> set timeout[ch], go to IDLE.
//   WAIT_DONE: on cmd_ready -> IDLE.
//   Latency: push at cycle t into an empty FIFO with cmd_ready high gives cmd_valid at t+2.
//   Channels run independently; no cross-channel ordering.
//  Reset (async assert, sync release):
//   - Outputs: buf_addr, avl_readdata, cmd_addr, cmd_data = 0; start_wr, cmd_valid = 0.
//   - FIFOs empty, sticky flags 0, all FSMs IDLE.
//   - Reset during WAIT_* abandons the command silently.
// TESTING
//  T1 wr 0x1234_5678 @1, rd @1 -> readdata 0x1234_5678 the next cycle; buf_addr[63:32] matches.
//  T2 wr 0xFFFF data 1 -> start_wr high exactly 1 cycle; data 0 -> start_wr stays 0.
//  T3 ch0 push {0x42,0x3008}, ready high, model drops ready 2 cycles later for 10 cycles
//     -> one cmd_valid, cmd_addr=0x3008, cmd_data=0x42, no reissue.
//  T4 ch1 ready held 0, push FIFO_DEPTH+1 -> STATUS[9]=1, exactly FIFO_DEPTH cmds issued
//     once ready rises; w1c 0x200 clears bit 9.
//  T5 ready stays 1 after issue -> timeout[ch] set after ACK_TMO cycles, next entry issued.
//  T6 reset_n low while ch0 WAIT_DONE with 3 queued -> all outputs 0, STATUS empty bits=1,
//     no cmd_valid after release.

Source files
------------

// File: rtl/hps_sensor_cfg_bank.sv
// HPS-to-FPGA sensor configuration bank: frame-buffer address registers, capture start
// strobe, and per-channel sensor register write FIFOs drained into SCCB/I2C masters.
`timescale 1ns/1ps
module hps_sensor_cfg_bank #(
    parameter int NUM_CH     = 2,
    parameter int NUM_BUF    = 4,
    parameter int REG_AW     = 16,
    parameter int REG_DW     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ACK_TMO    = 1023
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [15:0]              avl_address,
    input  logic                     avl_chipselect,
    input  logic                     avl_write,
    input  logic [31:0]              avl_writedata,
    input  logic                     avl_read,
    output logic [31:0]              avl_readdata,
    output logic [NUM_BUF*32-1:0]    buf_addr,
    output logic                     start_wr,
    output logic [NUM_CH-1:0]        cmd_valid,
    output logic [NUM_CH*REG_AW-1:0] cmd_addr,
    output logic [NUM_CH*REG_DW-1:0] cmd_data,
    input  logic [NUM_CH-1:0]        cmd_ready
);
    localparam int EW = REG_AW + REG_DW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(ACK_TMO + 1);
    localparam int BW = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam logic [15:0] ADDR_CMD    = 16'h8000;
    localparam logic [15:0] ADDR_STATUS = 16'hFFFE;
    localparam logic [15:0] ADDR_START  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    logic              wr_s, rd_s;
    logic [31:0]       buf_r [NUM_BUF];
    logic [31:0]       rdata_r, rdata_s, status_s;
    logic              start_r;
    logic [NUM_CH-1:0] empty_s, ovf_set_s, tmo_set_s, ovf_clr_s, tmo_clr_s;
    logic [NUM_CH-1:0] ovf_r, tmo_r;
    logic [7:0]        empty8_s, ovf8_s, tmo8_s;

    assign wr_s = avl_chipselect & avl_write;
    assign rd_s = avl_chipselect & avl_read;
    assign ovf_clr_s = (wr_s && avl_address == ADDR_STATUS) ? avl_writedata[8 +: NUM_CH]  : {NUM_CH{1'b0}};
    assign tmo_clr_s = (wr_s && avl_address == ADDR_STATUS) ? avl_writedata[16 +: NUM_CH] : {NUM_CH{1'b0}};

    // Buffer address registers and start strobe
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUF; i++) buf_r[i] <= 32'h0000_0000;
            start_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BUF; i++) begin
                if (wr_s && avl_address == 16'(i)) buf_r[i] <= avl_writedata;
            end
            start_r <= wr_s && (avl_address == ADDR_START) && avl_writedata[0];
        end
    end

    // Sticky flags: a same-cycle set wins over a clear so no event is lost
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ovf_r <= {NUM_CH{1'b0}};
            tmo_r <= {NUM_CH{1'b0}};
        end else begin
            ovf_r <= (ovf_r & ~ovf_clr_s) | ovf_set_s;
            tmo_r <= (tmo_r & ~tmo_clr_s) | tmo_set_s;
        end
    end

    // Status word assembly and read mux
    always_comb begin
        empty8_s = 8'h00;
        ovf8_s   = 8'h00;
        tmo8_s   = 8'h00;
        empty8_s[NUM_CH-1:0] = empty_s;
        ovf8_s[NUM_CH-1:0]   = ovf_r;
        tmo8_s[NUM_CH-1:0]   = tmo_r;
        status_s = {8'h00, tmo8_s, ovf8_s, empty8_s};
        if (avl_address == ADDR_STATUS) begin
            rdata_s = status_s;
        end else if (avl_address < 16'(NUM_BUF)) begin
            rdata_s = buf_r[avl_address[BW-1:0]];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Read data register, holds between reads
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_s) begin
            rdata_r <= rdata_s;
        end
    end

    assign avl_readdata = rdata_r;
    assign start_wr     = start_r;
    for (genvar i = 0; i < NUM_BUF; i++) begin : g_buf
        assign buf_addr[32*i +: 32] = buf_r[i];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [EW-1:0]     mem_r [FIFO_DEPTH];
        logic [PW-1:0]     wp_r, rp_r;
        logic [PW:0]       cnt_r;
        logic              push_s, push_ok_s, full_s, empty_ch_s, pop_s, tmo_hit_s;
        state_t            state_r, state_nx_s;
        logic [TW-1:0]     tmo_cnt_r;
        logic [REG_AW-1:0] addr_r;
        logic [REG_DW-1:0] data_r;
        logic              valid_r;

        assign push_s     = wr_s && (avl_address == (ADDR_CMD + 16'(c)));
        assign full_s     = (cnt_r == (PW+1)'(FIFO_DEPTH));
        assign empty_ch_s = (cnt_r == (PW+1)'(0));
        assign push_ok_s  = push_s && !full_s;

        // Entry storage; occupancy lives in the pointers, so no reset is needed here
        always_ff @(posedge clk_sys) begin
            if (push_ok_s) mem_r[wp_r] <= avl_writedata[EW-1:0];
        end

        // FIFO pointers and occupancy
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                wp_r  <= PW'(0);
                rp_r  <= PW'(0);
                cnt_r <= (PW+1)'(0);
            end else begin
                if (push_ok_s) wp_r <= wp_r + PW'(1);
                if (pop_s)     rp_r <= rp_r + PW'(1);
                case ({push_ok_s, pop_s})
                    2'b10:   cnt_r <= cnt_r + (PW+1)'(1);
                    2'b01:   cnt_r <= cnt_r - (PW+1)'(1);
                    default: cnt_r <= cnt_r;
                endcase
            end
        end

        // Drain FSM next-state: a busy response takes priority over the timeout
        always_comb begin
            state_nx_s = state_r;
            pop_s      = 1'b0;
            tmo_hit_s  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!empty_ch_s && cmd_ready[c]) begin
                        pop_s      = 1'b1;
                        state_nx_s = ST_ISSUE;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ISSUE: state_nx_s = ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (!cmd_ready[c]) begin
                        state_nx_s = ST_WAIT_DONE;
                    end else if (tmo_cnt_r == TW'(ACK_TMO)) begin
                        tmo_hit_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_DONE: begin
                    if (cmd_ready[c]) state_nx_s = ST_IDLE;
                    else              state_nx_s = ST_WAIT_DONE;
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end

        // Drain FSM state, command outputs and handshake timeout counter
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                state_r   <= ST_IDLE;
                valid_r   <= 1'b0;
                addr_r    <= {REG_AW{1'b0}};
                data_r    <= {REG_DW{1'b0}};
                tmo_cnt_r <= TW'(0);
            end else begin
                state_r <= state_nx_s;
                valid_r <= (state_nx_s == ST_ISSUE);
                if (pop_s) begin
                    addr_r <= mem_r[rp_r][REG_AW-1:0];
                    data_r <= mem_r[rp_r][EW-1:REG_AW];
                end
                if (state_r == ST_ISSUE) begin
                    tmo_cnt_r <= TW'(0);
                end else if (state_r == ST_WAIT_BUSY && tmo_cnt_r != TW'(ACK_TMO)) begin
                    tmo_cnt_r <= tmo_cnt_r + TW'(1);
                end
            end
        end

        assign cmd_valid[c]                  = valid_r;
        assign cmd_addr[c*REG_AW +: REG_AW]  = addr_r;
        assign cmd_data[c*REG_DW +: REG_DW]  = data_r;
        assign empty_s[c]                    = empty_ch_s;
        assign ovf_set_s[c]                  = push_s && full_s;
        assign tmo_set_s[c]                  = tmo_hit_s;
    end
endmodule

// File: tb/tb_hps_sensor_cfg_bank.sv
// Self-checking bench for hps_sensor_cfg_bank: directed scenarios followed by randomized
// register traffic and command streams checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_hps_sensor_cfg_bank;
    localparam int NUM_CH = 2, NUM_BUF = 4, REG_AW = 16, REG_DW = 8;
    localparam int FIFO_DEPTH = 16, ACK_TMO = 1023;
    localparam int EW = REG_AW + REG_DW;

    logic                     clk_sys = 1'b0;
    logic                     reset_n;
    logic [15:0]              avl_address;
    logic                     avl_chipselect, avl_write, avl_read;
    logic [31:0]              avl_writedata, avl_readdata;
    logic [NUM_BUF*32-1:0]    buf_addr;
    logic                     start_wr;
    logic [NUM_CH-1:0]        cmd_valid, cmd_ready;
    logic [NUM_CH*REG_AW-1:0] cmd_addr;
    logic [NUM_CH*REG_DW-1:0] cmd_data;

    always #5 clk_sys = ~clk_sys;

    hps_sensor_cfg_bank #(
        .NUM_CH(NUM_CH), .NUM_BUF(NUM_BUF), .REG_AW(REG_AW), .REG_DW(REG_DW),
        .FIFO_DEPTH(FIFO_DEPTH), .ACK_TMO(ACK_TMO)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .avl_address(avl_address),
        .avl_chipselect(avl_chipselect), .avl_write(avl_write), .avl_writedata(avl_writedata),
        .avl_read(avl_read), .avl_readdata(avl_readdata), .buf_addr(buf_addr),
        .start_wr(start_wr), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready)
    );

    int n_pass = 0, n_total = 0;
    logic [EW-1:0] issued_q [NUM_CH][$];
    logic [EW-1:0] exp_q    [NUM_CH][$];
    logic [31:0]   buf_m    [NUM_BUF];
    int            mode [NUM_CH];      // 0 responsive, 1 held busy, 2 never busy
    int            dly  [NUM_CH];
    int            busy_len [NUM_CH];
    int            sn_st [NUM_CH];
    int            sn_cnt [NUM_CH];
    logic [31:0]   rd_v, wd_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic avl_wr(input logic [15:0] a, input logic [31:0] d);
        avl_address = a; avl_writedata = d; avl_chipselect = 1'b1; avl_write = 1'b1;
        @(posedge clk_sys); #1;
        avl_chipselect = 1'b0; avl_write = 1'b0;
    endtask

    task automatic avl_rd(input logic [15:0] a, output logic [31:0] d);
        avl_address = a; avl_chipselect = 1'b1; avl_read = 1'b1;
        @(posedge clk_sys); #1;
        avl_chipselect = 1'b0; avl_read = 1'b0;
        d = avl_readdata;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk_sys); #1; end
    endtask

    task automatic wait_issued(input int c, input int n, input int budget, input string tag);
        int k = 0;
        while (issued_q[c].size() < n && k < budget) begin
            @(posedge clk_sys); #1;
            k++;
        end
        check(tag, 32'(issued_q[c].size()), 32'(n));
    endtask

    task automatic check_stream(input int c, input string tag);
        check({tag, "_count"}, 32'(issued_q[c].size()), 32'(exp_q[c].size()));
        for (int i = 0; i < exp_q[c].size() && i < issued_q[c].size(); i++)
            check(tag, 32'(issued_q[c][i]), 32'(exp_q[c][i]));
    endtask

    task automatic clear_queues();
        for (int c = 0; c < NUM_CH; c++) begin
            issued_q[c].delete();
            exp_q[c].delete();
        end
    endtask

    // Sensor master model: idle-ready, drops ready dly cycles after a command for busy_len cycles
    initial begin
        cmd_ready = {NUM_CH{1'b1}};
        for (int c = 0; c < NUM_CH; c++) begin sn_st[c] = 0; sn_cnt[c] = 0; end
        forever begin
            @(negedge clk_sys);
            for (int c = 0; c < NUM_CH; c++) begin
                if (mode[c] == 1) begin
                    cmd_ready[c] = 1'b0; sn_st[c] = 0;
                end else if (mode[c] == 2) begin
                    cmd_ready[c] = 1'b1; sn_st[c] = 0;
                end else if (sn_st[c] == 0) begin
                    cmd_ready[c] = 1'b1;
                    if (cmd_valid[c]) begin sn_st[c] = 1; sn_cnt[c] = dly[c]; end
                end else if (sn_st[c] == 1) begin
                    sn_cnt[c]--;
                    if (sn_cnt[c] <= 0) begin cmd_ready[c] = 1'b0; sn_st[c] = 2; sn_cnt[c] = busy_len[c]; end
                end else begin
                    sn_cnt[c]--;
                    if (sn_cnt[c] <= 0) begin cmd_ready[c] = 1'b1; sn_st[c] = 0; end
                end
            end
        end
    end

    // Command monitor
    initial begin
        forever begin
            @(negedge clk_sys);
            for (int c = 0; c < NUM_CH; c++)
                if (cmd_valid[c] === 1'b1)
                    issued_q[c].push_back({cmd_data[c*REG_DW +: REG_DW], cmd_addr[c*REG_AW +: REG_AW]});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        avl_address = 16'h0000; avl_chipselect = 1'b0; avl_write = 1'b0;
        avl_read = 1'b0; avl_writedata = 32'h0000_0000;
        for (int c = 0; c < NUM_CH; c++) begin mode[c] = 0; dly[c] = 2; busy_len[c] = 3; end
        for (int i = 0; i < NUM_BUF; i++) buf_m[i] = 32'h0000_0000;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys) reset_n = 1'b1;
        @(posedge clk_sys); #1;

        // Reset state
        for (int i = 0; i < NUM_BUF; i++) check("rst_buf_addr", buf_addr[32*i +: 32], 32'h0);
        check("rst_start_wr", 32'(start_wr), 32'h0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'h0);
        check("rst_cmd_data", 32'(cmd_data), 32'h0);
        check("rst_readdata", avl_readdata, 32'h0);
        avl_rd(16'hFFFE, rd_v);
        check("rst_status", rd_v, 32'h0000_0003);

        // T1: buffer register write/readback, hold, chipselect qualification
        avl_wr(16'h0001, 32'h1234_5678); buf_m[1] = 32'h1234_5678;
        check("t1_buf_addr1", buf_addr[63:32], 32'h1234_5678);
        avl_rd(16'h0001, rd_v);
        check("t1_readback", rd_v, 32'h1234_5678);
        cycles(1);
        check("t1_rd_hold", avl_readdata, 32'h1234_5678);
        avl_address = 16'h0001; avl_writedata = 32'hDEAD_BEEF; avl_write = 1'b1;
        cycles(1);
        avl_write = 1'b0;
        check("t1_no_cs_write", buf_addr[63:32], 32'h1234_5678);
        avl_rd(16'(NUM_BUF), rd_v);
        check("t1_unmapped_rd", rd_v, 32'h0);

        // T2: start strobe
        avl_wr(16'hFFFF, 32'h0000_0001);
        check("t2_start_hi", 32'(start_wr), 32'h1);
        cycles(1);
        check("t2_start_lo", 32'(start_wr), 32'h0);
        avl_wr(16'hFFFF, 32'hFFFF_FFFE);
        check("t2_start_d0", 32'(start_wr), 32'h0);
        cycles(1);
        check("t2_start_d0b", 32'(start_wr), 32'h0);

        // T3: single command on ch0, latency and no reissue
        clear_queues();
        dly[0] = 2; busy_len[0] = 10;
        avl_wr(16'h8000, 32'h0042_3008); exp_q[0].push_back(24'h42_3008);
        check("t3_lat_t1", 32'(cmd_valid[0]), 32'h0);
        cycles(1);
        check("t3_lat_t2", 32'(cmd_valid[0]), 32'h1);
        cycles(40);
        check_stream(0, "t3_stream");
        check("t3_addr_held", 32'(cmd_addr[15:0]), 32'h0000_3008);
        check("t3_data_held", 32'(cmd_data[7:0]), 32'h0000_0042);

        // T4: overflow on ch1 while the master is held busy
        clear_queues();
        mode[1] = 1; cycles(2);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            wd_v = $urandom;
            avl_wr(16'h8001, wd_v);
            if (i < FIFO_DEPTH) exp_q[1].push_back(wd_v[EW-1:0]);
        end
        avl_rd(16'hFFFE, rd_v);
        check("t4_status_ovf", rd_v, 32'h0000_0201);
        dly[1] = 1; busy_len[1] = 3; mode[1] = 0;
        wait_issued(1, FIFO_DEPTH, 2000, "t4_drain");
        cycles(30);
        check_stream(1, "t4_stream");
        avl_wr(16'hFFFE, 32'h0000_0200);
        avl_rd(16'hFFFE, rd_v);
        check("t4_status_w1c", rd_v, 32'h0000_0003);

        // T5: handshake timeout when the master never goes busy
        clear_queues();
        mode[0] = 2; cycles(2);
        avl_wr(16'h8000, 32'h0011_0101); exp_q[0].push_back(24'h11_0101);
        avl_wr(16'h8000, 32'h0022_0202); exp_q[0].push_back(24'h22_0202);
        wait_issued(0, 1, 10, "t5_first");
        cycles(ACK_TMO - 8);
        avl_rd(16'hFFFE, rd_v);
        check("t5_tmo_early", rd_v, 32'h0000_0002);
        wait_issued(0, 2, 40, "t5_second");
        avl_rd(16'hFFFE, rd_v);
        check("t5_tmo_set", rd_v, 32'h0001_0003);
        check_stream(0, "t5_stream");
        cycles(ACK_TMO + 20);
        avl_wr(16'hFFFE, 32'h0001_0000);
        avl_rd(16'hFFFE, rd_v);
        check("t5_tmo_w1c", rd_v, 32'h0000_0003);
        mode[0] = 0;

        // T6: asynchronous reset while ch0 waits for completion with entries queued
        clear_queues();
        dly[0] = 1; busy_len[0] = 60; cycles(2);
        for (int i = 0; i < 4; i++) avl_wr(16'h8000, 32'h0055_1000 + 32'(i));
        wait_issued(0, 1, 10, "t6_first");
        cycles(10);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_BUF; i++) check("t6_buf_addr", buf_addr[32*i +: 32], 32'h0);
        check("t6_readdata", avl_readdata, 32'h0);
        check("t6_cmd_addr", 32'(cmd_addr), 32'h0);
        check("t6_cmd_data", 32'(cmd_data), 32'h0);
        check("t6_cmd_valid", 32'(cmd_valid), 32'h0);
        check("t6_start_wr", 32'(start_wr), 32'h0);
        for (int i = 0; i < NUM_BUF; i++) buf_m[i] = 32'h0000_0000;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys) reset_n = 1'b1;
        @(posedge clk_sys); #1;
        avl_rd(16'hFFFE, rd_v);
        check("t6_status", rd_v, 32'h0000_0003);
        cycles(100);
        check("t6_no_reissue", 32'(issued_q[0].size()), 32'h1);

        // Randomized rounds: register traffic and command streams against the model
        for (int r = 0; r < 6; r++) begin
            int pc [NUM_CH];
            int n, ch, bi;
            logic [15:0] ua;
            clear_queues();
            for (int c = 0; c < NUM_CH; c++) begin
                dly[c] = $urandom_range(1, 3); busy_len[c] = $urandom_range(1, 6); pc[c] = 0;
            end
            for (int k = 0; k < 3; k++) begin
                bi = $urandom_range(0, NUM_BUF - 1);
                wd_v = $urandom;
                avl_wr(16'(bi), wd_v); buf_m[bi] = wd_v;
            end
            for (int i = 0; i < NUM_BUF; i++) begin
                avl_rd(16'(i), rd_v);
                check("rnd_buf_rd", rd_v, buf_m[i]);
            end
            ua = 16'($urandom_range(NUM_BUF, 16'h7FFF));
            avl_rd(ua, rd_v);
            check("rnd_unmapped_rd", rd_v, 32'h0);
            avl_rd(16'h8000 + 16'(r % 8), rd_v);
            check("rnd_cmd_addr_rd", rd_v, 32'h0);
            n = $urandom_range(4, 24);
            for (int k = 0; k < n; k++) begin
                ch = $urandom_range(0, 3);
                wd_v = $urandom;
                if (ch >= NUM_CH) begin
                    avl_wr(16'h8000 + 16'(ch), wd_v);
                end else if (pc[ch] < FIFO_DEPTH) begin
                    avl_wr(16'h8000 + 16'(ch), wd_v);
                    exp_q[ch].push_back(wd_v[EW-1:0]);
                    pc[ch]++;
                end
            end
            for (int c = 0; c < NUM_CH; c++) wait_issued(c, exp_q[c].size(), 1500, "rnd_drain");
            cycles(20);
            for (int c = 0; c < NUM_CH; c++) check_stream(c, "rnd_stream");
            avl_rd(16'hFFFE, rd_v);
            check("rnd_status", rd_v, 32'h0000_0003);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
